// File: rtl/oled_seq_ctrl_if.sv
// Host byte stream, SPI byte-engine handshake and panel pin bundle for the OLED sequencer.
// master = sequencer side, slave = host/engine/panel side.
interface oled_seq_ctrl_if;
   logic       start;
   logic       off_req;
   logic       host_valid;
   logic       host_dc;
   logic [7:0] host_data;
   logic       host_ready;
   logic       spi_en;
   logic [7:0] spi_data;
   logic       spi_fin;
   logic       dc;
   logic       res_n;
   logic       vdd_n;
   logic       vbat_n;
   logic       init_done;
   logic       busy;

   modport master (
      input  start, off_req, host_valid, host_dc, host_data, spi_fin,
      output host_ready, spi_en, spi_data, dc, res_n, vdd_n, vbat_n, init_done, busy
   );

   modport slave (
      output start, off_req, host_valid, host_dc, host_data, spi_fin,
      input  host_ready, spi_en, spi_data, dc, res_n, vdd_n, vbat_n, init_done, busy
   );
endinterface

// File: rtl/oled_seq_ctrl.sv
// SSD1306 power/init sequencer and host byte arbiter; a host byte is accepted in READY and takes one engine byte time + ~4 cycles.
// Backpressure: host_ready only in READY. Define OLED_FAST_SIM_EN to shrink 1 ms to 16 cycles.
module oled_seq_ctrl #(
   parameter int MS_CYCLES = 100000,
   parameter int RES_MS    = 1,
   parameter int VDD_MS    = 1,
   parameter int VBAT_MS   = 100
) (
   input  logic            clk,
   input  logic            rst_n,
   oled_seq_ctrl_if.master bus
);

`ifdef OLED_FAST_SIM_EN
   localparam logic [16:0] PSC_TC = 17'd15;
`else
   localparam logic [16:0] PSC_TC = 17'(MS_CYCLES - 1);
`endif

   typedef enum logic [3:0] {
      S_OFF, S_VDD_ON, S_RES_LO, S_RES_HI, S_CMD1, S_VBAT_ON, S_CMD2, S_READY,
      S_XFER, S_PD_CMD, S_PD_VBAT, S_PD_VDD, S_SEND_REQ, S_SEND_REL
   } state_t;

   state_t      state, state_nxt, ret_state;
   logic [3:0]  ptr;
   logic [16:0] psc;
   logic [7:0]  ms_cnt;
   logic [7:0]  spi_data_q;
   logic        dc_q, res_n_q, vdd_n_q, vbat_n_q, init_q;
   logic        tick, dly_done;

   assign tick     = (psc == PSC_TC);
   assign dly_done = tick && (ms_cnt == 8'd1);

   function automatic logic [7:0] cmd_rom(input logic list2, input logic [3:0] a);
      logic [7:0] b;
      case ({list2, a})
         5'h00: b = 8'hAE;  5'h01: b = 8'h8D;  5'h02: b = 8'h14;
         5'h03: b = 8'hD9;  5'h04: b = 8'hF1;
         5'h10: b = 8'h81;  5'h11: b = 8'h0F;  5'h12: b = 8'hA1;
         5'h13: b = 8'hC8;  5'h14: b = 8'hDA;  5'h15: b = 8'h20;
         5'h16: b = 8'hAF;
         default: b = 8'hAE;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] dly_ms(input state_t s);
      logic [7:0] n;
      case (s)
         S_VDD_ON:             n = 8'(VDD_MS);
         S_RES_LO, S_RES_HI:   n = 8'(RES_MS);
         S_VBAT_ON, S_PD_VBAT: n = 8'(VBAT_MS);
         default:              n = 8'd0;
      endcase
      return n;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_OFF;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_OFF:      if (bus.start) state_nxt = S_VDD_ON;
         S_VDD_ON:   if (dly_done) state_nxt = S_RES_LO;
         S_RES_LO:   if (dly_done) state_nxt = S_RES_HI;
         S_RES_HI:   if (dly_done) state_nxt = S_CMD1;
         S_CMD1:     state_nxt = (ptr == 4'd5) ? S_VBAT_ON : S_SEND_REQ;
         S_VBAT_ON:  if (dly_done) state_nxt = S_CMD2;
         S_CMD2:     state_nxt = (ptr == 4'd7) ? S_READY : S_SEND_REQ;
         S_READY: begin
            // a host byte beats a simultaneous off_req; off_req is seen again on return
            if (bus.host_valid)   state_nxt = S_XFER;
            else if (bus.off_req) state_nxt = S_PD_CMD;
         end
         S_XFER:     state_nxt = S_SEND_REQ;
         S_PD_CMD:   state_nxt = (ptr == 4'd1) ? S_PD_VBAT : S_SEND_REQ;
         S_PD_VBAT:  if (dly_done) state_nxt = S_PD_VDD;
         S_PD_VDD:   state_nxt = S_OFF;
         S_SEND_REQ: if (bus.spi_fin) state_nxt = S_SEND_REL;
         S_SEND_REL: if (!bus.spi_fin) state_nxt = ret_state;
         default:    state_nxt = S_OFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret_state  <= S_OFF;
         ptr        <= 4'd0;
         psc        <= 17'd0;
         ms_cnt     <= 8'd0;
         spi_data_q <= 8'h00;
         dc_q       <= 1'b0;
         res_n_q    <= 1'b1;
         vdd_n_q    <= 1'b1;
         vbat_n_q   <= 1'b1;
         init_q     <= 1'b0;
      end else begin
         // delay restarts on every state change so each wait is exactly N ms
         if (state != state_nxt) begin
            psc    <= 17'd0;
            ms_cnt <= dly_ms(state_nxt);
            case (state_nxt)
               S_VDD_ON:  vdd_n_q  <= 1'b0;
               S_RES_LO:  res_n_q  <= 1'b0;
               S_RES_HI:  res_n_q  <= 1'b1;
               S_VBAT_ON: vbat_n_q <= 1'b0;
               S_READY:   init_q   <= 1'b1;
               S_PD_CMD:  init_q   <= 1'b0;
               S_PD_VBAT: vbat_n_q <= 1'b1;
               S_PD_VDD: begin
                  vdd_n_q <= 1'b1;
                  res_n_q <= 1'b1;
               end
               default: ;
            endcase
         end else begin
            psc <= tick ? 17'd0 : psc + 17'd1;
            if (tick && ms_cnt != 8'd0) ms_cnt <= ms_cnt - 8'd1;
         end

         if ((state == S_RES_HI && state_nxt == S_CMD1) ||
             (state == S_VBAT_ON && state_nxt == S_CMD2) ||
             (state == S_READY && state_nxt == S_PD_CMD))
            ptr <= 4'd0;

         if (state == S_READY && bus.host_valid) begin
            spi_data_q <= bus.host_data;
            dc_q       <= bus.host_dc;
         end

         // byte and D/C only change here, where spi_en and spi_fin are both low
         if (state != S_SEND_REQ && state_nxt == S_SEND_REQ) begin
            case (state)
               S_CMD1: begin
                  spi_data_q <= cmd_rom(1'b0, ptr);
                  dc_q       <= 1'b0;
                  ptr        <= ptr + 4'd1;
                  ret_state  <= S_CMD1;
               end
               S_CMD2: begin
                  spi_data_q <= cmd_rom(1'b1, ptr);
                  dc_q       <= 1'b0;
                  ptr        <= ptr + 4'd1;
                  ret_state  <= S_CMD2;
               end
               S_PD_CMD: begin
                  spi_data_q <= 8'hAE;
                  dc_q       <= 1'b0;
                  ptr        <= ptr + 4'd1;
                  ret_state  <= S_PD_CMD;
               end
               default: ret_state <= S_READY;
            endcase
         end
      end
   end

   assign bus.spi_en     = (state == S_SEND_REQ);
   assign bus.spi_data   = spi_data_q;
   assign bus.dc         = dc_q;
   assign bus.res_n      = res_n_q;
   assign bus.vdd_n      = vdd_n_q;
   assign bus.vbat_n     = vbat_n_q;
   assign bus.host_ready = (state == S_READY);
   assign bus.init_done  = init_q;
   assign bus.busy       = (state != S_OFF) && (state != S_READY);

endmodule

// File: tb/tb_oled_seq_ctrl.sv
// Directed bench for oled_seq_ctrl with a 16-cycle millisecond and a behavioural SPI byte engine.
module tb_oled_seq_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   oled_seq_ctrl_if bus ();

   oled_seq_ctrl #(.MS_CYCLES(16), .RES_MS(1), .VDD_MS(1), .VBAT_MS(100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int errs    = 0;
   int cyc     = 0;
   int fin_hold = 1;
   logic [8:0] log_q [$];
   int         en_cyc [$];
   int         en_cnt = 0;
   int         rel_cnt = 0;
   logic       en_prev = 1'b0;
   logic [8:0] held = 9'h0;
   int         unstable = 0;
   logic [7:0] cmd1 [5] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1};
   logic [7:0] cmd2 [7] = '{8'h81, 8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};

   always @(posedge clk) cyc = cyc + 1;

   // byte logger, stability monitor and SPI engine model
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.spi_fin = 1'b0;
         en_cnt  = 0;
         rel_cnt = 0;
         en_prev = 1'b0;
      end else begin
         if (bus.spi_en && !en_prev) begin
            log_q.push_back({bus.dc, bus.spi_data});
            en_cyc.push_back(cyc);
            held = {bus.dc, bus.spi_data};
         end else if ((bus.spi_en || bus.spi_fin) && ({bus.dc, bus.spi_data} !== held)) begin
            unstable++;
         end
         en_prev = bus.spi_en;
         if (bus.spi_en) begin
            rel_cnt = 0;
            if (!bus.spi_fin) begin
               en_cnt++;
               if (en_cnt >= 20) begin
                  bus.spi_fin = 1'b1;
                  en_cnt = 0;
               end
            end
         end else if (bus.spi_fin) begin
            rel_cnt++;
            if (rel_cnt >= fin_hold) begin
               bus.spi_fin = 1'b0;
               rel_cnt = 0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n, t0, bm;
      bus.start = 1'b0; bus.off_req = 1'b0; bus.host_valid = 1'b0;
      bus.host_dc = 1'b0; bus.host_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_spi_en", bus.spi_en, 0);
      chk("rst_spi_data", bus.spi_data, 8'h00);
      chk("rst_dc", bus.dc, 0);
      chk("rst_res_n", bus.res_n, 1);
      chk("rst_vdd_n", bus.vdd_n, 1);
      chk("rst_vbat_n", bus.vbat_n, 1);
      chk("rst_host_ready", bus.host_ready, 0);
      chk("rst_init_done", bus.init_done, 0);
      chk("rst_busy", bus.busy, 0);

      // power-up, with off_req pulsed during RES_LO
      rst_n = 1'b1;
      @(negedge clk);
      bus.start = 1'b1;
      for (int i = 0; i < 100 && bus.vdd_n; i++) @(negedge clk);
      chk("vdd_on", bus.vdd_n, 0);
      chk("busy_powerup", bus.busy, 1);
      n = 0;
      while (bus.res_n && n < 100) begin @(negedge clk); n++; end
      chk("vdd_settle_cycles", n, 16);
      bus.off_req = 1'b1;
      n = 0;
      while (!bus.res_n && n < 100) begin @(negedge clk); n++; end
      chk("res_low_cycles", n, 16);
      bus.off_req = 1'b0;
      for (int i = 0; i < 3000 && log_q.size() < 5; i++) @(negedge clk);
      chk("cmd1_count", log_q.size(), 5);
      chk("vbat_before_cmd1_end", bus.vbat_n, 1);
      for (int i = 0; i < 5; i++) chk($sformatf("cmd1_byte%0d", i), log_q[i], {1'b0, cmd1[i]});
      for (int i = 0; i < 300 && bus.vbat_n; i++) @(negedge clk);
      chk("vbat_on", bus.vbat_n, 0);
      t0 = cyc;
      for (int i = 0; i < 5000 && log_q.size() < 12; i++) @(negedge clk);
      chk("cmd2_count", log_q.size(), 12);
      chk("vbat_to_cmd2_cycles", en_cyc[5] - t0, 1601);
      for (int i = 0; i < 7; i++) chk($sformatf("cmd2_byte%0d", i), log_q[5 + i], {1'b0, cmd2[i]});
      for (int i = 0; i < 300 && !bus.init_done; i++) @(negedge clk);
      chk("init_done", bus.init_done, 1);
      chk("ready_host_ready", bus.host_ready, 1);
      chk("ready_busy", bus.busy, 0);

      // start held high in READY does nothing
      repeat (10) @(negedge clk);
      chk("start_ignored_bytes", log_q.size(), 12);
      chk("start_ignored_ready", bus.host_ready, 1);
      bus.start = 1'b0;

      // host transfer
      bus.host_valid = 1'b1; bus.host_dc = 1'b1; bus.host_data = 8'h5A;
      @(negedge clk);
      bus.host_valid = 1'b0;
      chk("host_ready_drop", bus.host_ready, 0);
      for (int i = 0; i < 300 && !bus.host_ready; i++) @(negedge clk);
      chk("host_ready_back", bus.host_ready, 1);
      chk("fin_low_at_ready", bus.spi_fin, 0);
      chk("host_byte_count", log_q.size(), 13);
      chk("host_byte", log_q[12], 9'h15A);

      // engine holds spi_fin 50 cycles after spi_en drops
      fin_hold = 50;
      bus.host_valid = 1'b1; bus.host_dc = 1'b0; bus.host_data = 8'h3C;
      @(negedge clk);
      bus.host_valid = 1'b0;
      for (int i = 0; i < 300 && !(log_q.size() == 14 && !bus.spi_en); i++) @(negedge clk);
      t0 = cyc;
      for (int i = 0; i < 300 && !bus.host_ready; i++) @(negedge clk);
      chk("hold_gap_ge50", (cyc - t0) >= 50, 1);
      chk("hold_byte_count", log_q.size(), 14);
      chk("hold_byte", log_q[13], 9'h03C);
      chk("stable_data_dc", unstable, 0);
      fin_hold = 1;

      // host byte and off_req together: byte first, then power-down
      bus.host_valid = 1'b1; bus.off_req = 1'b1; bus.host_dc = 1'b1; bus.host_data = 8'h77;
      @(negedge clk);
      bus.host_valid = 1'b0;
      for (int i = 0; i < 500 && log_q.size() < 16; i++) @(negedge clk);
      chk("pd_byte_count", log_q.size(), 16);
      chk("pd_host_first", log_q[14], 9'h177);
      chk("pd_display_off", log_q[15], 9'h0AE);
      for (int i = 0; i < 300 && !bus.vbat_n; i++) @(negedge clk);
      chk("pd_vbat_off", bus.vbat_n, 1);
      t0 = cyc;
      for (int i = 0; i < 3000 && !bus.vdd_n; i++) @(negedge clk);
      chk("pd_vbat_to_vdd_cycles", cyc - t0, 1600);
      bus.off_req = 1'b0;
      @(negedge clk);
      chk("off_busy", bus.busy, 0);
      chk("off_init_done", bus.init_done, 0);
      chk("off_host_ready", bus.host_ready, 0);
      chk("off_res_n", bus.res_n, 1);

      // reset in the middle of CMD2 with spi_en high
      bus.start = 1'b1;
      for (int i = 0; i < 5000 && !(!bus.vbat_n && bus.spi_en); i++) @(negedge clk);
      chk("midrst_reached", bus.spi_en && !bus.vbat_n, 1);
      bus.start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_spi_en", bus.spi_en, 0);
      chk("midrst_vdd_n", bus.vdd_n, 1);
      chk("midrst_vbat_n", bus.vbat_n, 1);
      chk("midrst_res_n", bus.res_n, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bm = log_q.size();
      @(negedge clk);
      bus.start = 1'b1;
      for (int i = 0; i < 3000 && log_q.size() < bm + 5; i++) @(negedge clk);
      chk("replay_count", log_q.size(), bm + 5);
      for (int i = 0; i < 5; i++) chk($sformatf("replay_byte%0d", i), log_q[bm + i], {1'b0, cmd1[i]});
      bus.start = 1'b0;
      for (int i = 0; i < 5000 && !bus.init_done; i++) @(negedge clk);
      chk("replay_init_done", bus.init_done, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/oled_seq_ctrl.md
Name: oled_seq_ctrl

Overview:
- Sequences the SPI byte engine (spi_en / spi_data / spi_fin handshake) for the SSD1306-class OLED panel.
- Runs power-up: VDD on, panel reset, fixed command lists, then VBAT on.
- After power-up, arbitrates a single host byte stream onto the engine with D/C control.
- Runs power-down on request and owns all panel power and reset pins.

Parameters:
- MS_CYCLES, 100000, clk cycles per millisecond (100 MHz).
- RES_MS, 1, reset-low time and reset settle time, ms.
- VDD_MS, 1, VDD settle time, ms.
- VBAT_MS, 100, VBAT on/off settle time, ms.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begin power-up when in OFF.
- off_req  in  1  level; begin power-down when in READY.
- host_valid  in  1  host byte valid.
- host_dc  in  1  host D/C: 0 = command, 1 = data.
- host_data  in  8  host byte.
- host_ready  out  1  sequencer accepts a host byte this cycle.
- spi_en  out  1  request to the SPI engine.
- spi_data  out  8  byte to the SPI engine.
- spi_fin  in  1  engine done; held until spi_en drops.
- dc  out  1  panel D/C pin.
- res_n  out  1  panel reset pin, active low.
- vdd_n  out  1  logic supply enable, active low.
- vbat_n  out  1  panel supply enable, active low.
- init_done  out  1  high in READY and XFER.
- busy  out  1  high in every state except OFF and READY.

Behaviour:
- Reset values: spi_en=0, spi_data=0x00, dc=0, res_n=1, vdd_n=1, vbat_n=1, host_ready=0, init_done=0, busy=0; state OFF.
- Byte send subroutine:
  - SEND_REQ: drive spi_en=1 with spi_data stable; wait for spi_fin=1.
  - SEND_REL: drive spi_en=0; wait for spi_fin=0.
  - Then jump to the stored return state.
  - spi_data and dc never change while spi_en=1 or spi_fin=1.
- Delay unit: a 17-bit prescaler produces a 1-cycle ms tick; an 8-bit ms counter loads N and counts down on ticks. The delay ends on the tick where the counter reaches 0. Total delay is N*MS_CYCLES cycles, within 1 cycle.
- States and transitions:
  - OFF: start=1 → VDD_ON.
  - VDD_ON: vdd_n=0; wait VDD_MS → RES_LO.
  - RES_LO: res_n=0; wait RES_MS → RES_HI.
  - RES_HI: res_n=1; wait RES_MS → CMD1.
  - CMD1: send, dc=0, in order: 0xAE, 0x8D, 0x14, 0xD9, 0xF1 → VBAT_ON.
  - VBAT_ON: vbat_n=0; wait VBAT_MS → CMD2.
  - CMD2: send, dc=0, in order: 0x81, 0x0F, 0xA1, 0xC8, 0xDA, 0x20, 0xAF → READY.
  - READY: host_ready=1; init_done=1.
    - host_valid=1 → latch host_data and host_dc, then XFER. host_ready drops the next cycle.
    - off_req=1 with host_valid=0 → PD_CMD.
    - host_valid and off_req both high in the same cycle: the host byte wins; off_req is re-evaluated on return to READY.
  - XFER: send the latched byte with dc=latched host_dc → READY.
  - PD_CMD: send 0xAE, dc=0 → PD_VBAT.
  - PD_VBAT: vbat_n=1; wait VBAT_MS → PD_VDD.
  - PD_VDD: vdd_n=1, res_n=1 → OFF.
- Command lists come from an internal ROM indexed by a 4-bit pointer; the pointer clears on entry to CMD1 and CMD2.
- start is ignored outside OFF. off_req is ignored outside READY, including during power-up; it is not queued.
- Throughput: one host byte per SPI engine byte time plus 4 cycles minimum overhead.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronous). The panel therefore loses power with no 0xAE sent; this is accepted.
- Unknown state encoding → OFF.

Optional Feature:
- Macro OLED_FAST_SIM_EN.
- Defined: the prescaler terminal count is 15, so 1 ms = 16 cycles. All sequencing is otherwise identical; used for simulation.
- Undefined: the terminal count is MS_CYCLES-1.

Test Plan:
- Power-up with OLED_FAST_SIM_EN (SPI engine model: fin 20 cycles after en, clears 1 cycle after en drops): rst_n 0→1, start=1 →
  - vdd_n falls; res_n low for 16 cycles.
  - spi_data sequence AE,8D,14,D9,F1 with dc=0.
  - vbat_n falls; 1600 cycles later AF is the final byte.
  - init_done=1, host_ready=1.
- Host transfer: in READY, host_valid=1, host_dc=1, host_data=0x5A → host_ready=0 next cycle; one spi_en pulse with spi_data=0x5A, dc=1; host_ready returns to 1 only after spi_fin=0.
- Handshake hold: engine model holds spi_fin=1 for 50 cycles after spi_en drops → no new spi_en until spi_fin=0; spi_data and dc stable throughout.
- Simultaneous events: host_valid=1 and off_req=1 in the same READY cycle → host byte sent first, then 0xAE with dc=0; vbat_n rises, and 1600 cycles later vdd_n rises; state OFF, busy=0.
- Mid-sequence reset: rst_n=0 during CMD2 with spi_en=1 → spi_en=0, vdd_n=1, vbat_n=1, res_n=1 in the same cycle; after release, start=1 replays the full sequence from 0xAE.
- Ignored inputs: off_req=1 during RES_LO → no effect, sequence completes to READY; start=1 in READY → no effect.
